keypad_scan_ctrl: RTL and testbench

Scan controller for the 3x4 matrix keypad peripheral on the RAT I/O bus. It owns the column strobes, dwelling on each column for a programmable number of clocks rather than switching every clock, and samples the three row lines. It debounces presses and releases over whole scan frames and reports one key code per physical press. Reporting uses a valid/ack handshake plus a one-cycle interrupt pulse to the RAT CPU.

---
 rtl/keypad_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 3x4 matrix keypad scanner: column strobe with programmable dwell, whole-frame
// capture, press/release debounce FSM and valid/ack + interrupt reporting.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       intr,
  output logic       overrun
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE_DB} state_t;

  logic [PW-1:0] presc_q;
  logic [3:0]    col_q;
  logic          cap_vld_q;
  logic [3:0]    cap_code_q;
  logic          tick, frame_end;
  logic          samp_hit, fr_hit;
  logic [3:0]    samp_code, fr_code;

  state_t        state_q;
  logic [3:0]    cand_q;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic [3:0]    key_code_q;
  logic          key_valid_q, intr_q, overrun_q;
  logic          accept;
  logic [3:0]    acc_code;

  assign tick      = (presc_q == PW'(SCAN_DIV - 1));
  assign frame_end = tick & col_q[3];
  assign samp_hit  = |row;

  // Row priority C > A > E within the driven column.
  always_comb begin
    samp_code = 4'd0;
    case (col_q)
      4'b0001: samp_code = row[0] ? 4'd1  : row[1] ? 4'd2 : 4'd3;
      4'b0010: samp_code = row[0] ? 4'd4  : row[1] ? 4'd5 : 4'd6;
      4'b0100: samp_code = row[0] ? 4'd7  : row[1] ? 4'd8 : 4'd9;
      default: samp_code = row[0] ? 4'd10 : row[1] ? 4'd0 : 4'd11;
    endcase
  end

  // The col3 sample on the frame-end tick still belongs to the closing frame.
  assign fr_hit  = cap_vld_q | samp_hit;
  assign fr_code = cap_vld_q ? cap_code_q : samp_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      col_q      <= 4'b0001;
      cap_vld_q  <= 1'b0;
      cap_code_q <= 4'd0;
    end else if (tick) begin
      presc_q <= '0;
      col_q   <= {col_q[2:0], col_q[3]};
      if (frame_end) begin
        cap_vld_q  <= 1'b0;
        cap_code_q <= 4'd0;
      end else if (!cap_vld_q && samp_hit) begin
        cap_vld_q  <= 1'b1;
        cap_code_q <= samp_code;
      end
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    accept   = 1'b0;
    acc_code = cand_q;
    if (frame_end && fr_hit) begin
      case (state_q)
        IDLE: if (DEBOUNCE_SCANS == 1) begin
          accept   = 1'b1;
          acc_code = fr_code;
        end
        DEBOUNCE: if (fr_code == cand_q && cnt_inc == CW'(DEBOUNCE_SCANS)) accept = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      intr_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      intr_q <= accept;
      if (accept) begin
        key_code_q  <= acc_code;
        key_valid_q <= 1'b1;
        // An ack on the accept cycle retires the old key, so no overrun.
        overrun_q   <= key_valid_q & ~key_ack;
      end else if (key_ack && key_valid_q) begin
        key_valid_q <= 1'b0;
        overrun_q   <= 1'b0;
      end

      if (frame_end) begin
        case (state_q)
          IDLE: if (fr_hit) begin
            cand_q <= fr_code;
            cnt_q  <= CW'(1);
            state_q <= (DEBOUNCE_SCANS == 1) ? HELD : DEBOUNCE;
          end
          DEBOUNCE: begin
            if (!fr_hit) begin
              state_q <= IDLE;
            end else if (fr_code != cand_q) begin
              cand_q <= fr_code;
              cnt_q  <= CW'(1);
            end else if (accept) begin
              state_q <= HELD;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          HELD: if (!fr_hit) begin
            cnt_q   <= CW'(1);
            state_q <= (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE_DB;
          end
          default: begin
            if (fr_hit) state_q <= HELD;
            else if (cnt_inc == CW'(DEBOUNCE_SCANS)) state_q <= IDLE;
            else cnt_q <= cnt_inc;
          end
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign intr      = intr_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: emulates the key matrix from col, scoreboards
// expected key reports against intr pulses.
module tb_keypad_scan_ctrl;
  localparam int SD = 4;
  localparam int DS = 2;
  localparam int K1 = 0, K5 = 4, K7 = 6, K9 = 8, K0 = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] row;
  logic [3:0] col, key_code;
  logic       key_valid, intr, overrun;
  logic       key_ack = 1'b0;
  logic [11:0] keys = '0;

  int tests = 0, fails = 0, intr_cnt = 0, cyc = 0;
  logic [3:0] exp_q[$];

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .intr(intr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  always_comb begin
    row = 3'b000;
    for (int c = 0; c < 4; c++)
      if (col[c])
        for (int r = 0; r < 3; r++) row[r] = keys[c*3 + r];
  end

  // Every intr cycle must match the next expected report.
  always @(negedge clk) begin
    if (rst_n && intr) begin
      logic [3:0] e;
      intr_cnt = intr_cnt + 1;
      tests = tests + 1;
      if (exp_q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_intr key_code=%0d expected no report", key_code);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e || key_valid !== 1'b1) begin
          fails = fails + 1;
          $display("FAIL report key_code=%0d valid=%b expected code=%0d valid=1",
                   key_code, key_valid, e);
        end
      end
    end
  end

  task automatic to_frame_end();
    do begin
      @(posedge clk); #1;
    end while (cyc % 16 != 0);
  endtask

  task automatic frames(input int n);
    repeat (n) to_frame_end();
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(posedge clk); #1;
    key_ack = 1'b0;
  endtask

  task automatic ack_at_frame_end();
    do begin
      @(posedge clk); #1;
    end while (cyc % 16 != 15);
    key_ack = 1'b1;
    @(posedge clk); #1;
    key_ack = 1'b0;
  endtask

  task automatic test_reset();
    keys = '0;
    #12;
    tests++;
    if (col !== 4'b0001 || key_code !== 4'd0 || key_valid !== 1'b0 || intr !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_state col=%b code=%0d v=%b i=%b o=%b expected 0001/0/0/0/0",
               col, key_code, key_valid, intr, overrun);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (col !== 4'b0010) begin
      fails++;
      $display("FAIL col_after_4 col=%b expected 0010", col);
    end
    repeat (12) @(posedge clk);
    #1;
    tests++;
    if (col !== 4'b0001) begin
      fails++;
      $display("FAIL col_after_16 col=%b expected 0001", col);
    end
    frames(2);
    tests++;
    if (intr_cnt !== 0) begin
      fails++;
      $display("FAIL idle_intr count=%0d expected 0", intr_cnt);
    end
  endtask

  task automatic test_press_ack();
    keys = '0; keys[K5] = 1'b1;
    exp_q.push_back(4'd5);
    frames(2);
    tests++;
    if (intr !== 1'b1 || key_code !== 4'd5 || key_valid !== 1'b1) begin
      fails++;
      $display("FAIL press_latency intr=%b code=%0d v=%b expected 1/5/1", intr, key_code, key_valid);
    end
    frames(2);
    keys = '0;
    ack_pulse();
    tests++;
    if (key_valid !== 1'b0 || key_code !== 4'd5) begin
      fails++;
      $display("FAIL ack_clear v=%b code=%0d expected 0/5", key_valid, key_code);
    end
    frames(2);
  endtask

  task automatic test_bounce();
    int n0;
    n0 = intr_cnt;
    for (int i = 0; i < 5; i++) begin
      keys = '0; keys[K5] = 1'b1;
      frames(1);
      keys = '0;
      frames(1);
    end
    tests++;
    if (intr_cnt - n0 !== 0 || key_valid !== 1'b0) begin
      fails++;
      $display("FAIL bounce intrs=%0d v=%b expected 0/0", intr_cnt - n0, key_valid);
    end
  endtask

  task automatic test_hold_release();
    int n0;
    n0 = intr_cnt;
    keys = '0; keys[K5] = 1'b1;
    exp_q.push_back(4'd5);
    frames(10);
    tests++;
    if (intr_cnt - n0 !== 1) begin
      fails++;
      $display("FAIL hold_once intrs=%0d expected 1", intr_cnt - n0);
    end
    ack_pulse();
    keys = '0;
    frames(2);
    keys[K0] = 1'b1;
    exp_q.push_back(4'd0);
    frames(3);
    tests++;
    if (intr_cnt - n0 !== 2 || key_code !== 4'd0) begin
      fails++;
      $display("FAIL second_press intrs=%0d code=%0d expected 2/0", intr_cnt - n0, key_code);
    end
    keys = '0;
    frames(1);
    keys[K0] = 1'b1;
    frames(2);
    keys = '0;
    tests++;
    if (intr_cnt - n0 !== 2) begin
      fails++;
      $display("FAIL short_release intrs=%0d expected 2", intr_cnt - n0);
    end
    frames(2);
    ack_pulse();
  endtask

  task automatic test_overrun();
    keys = '0; keys[K5] = 1'b1;
    exp_q.push_back(4'd5);
    frames(2);
    keys = '0;
    frames(2);
    keys[K9] = 1'b1;
    exp_q.push_back(4'd9);
    frames(2);
    tests++;
    if (key_code !== 4'd9 || key_valid !== 1'b1 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun code=%0d v=%b o=%b expected 9/1/1", key_code, key_valid, overrun);
    end
    keys = '0;
    ack_pulse();
    tests++;
    if (key_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_ack v=%b o=%b expected 0/0", key_valid, overrun);
    end
    frames(2);
    keys[K5] = 1'b1;
    exp_q.push_back(4'd5);
    frames(2);
    keys = '0;
    frames(2);
    keys[K9] = 1'b1;
    exp_q.push_back(4'd9);
    frames(1);
    ack_at_frame_end();
    tests++;
    if (key_valid !== 1'b1 || overrun !== 1'b0 || key_code !== 4'd9 || intr !== 1'b1) begin
      fails++;
      $display("FAIL ack_with_accept v=%b o=%b code=%0d i=%b expected 1/0/9/1",
               key_valid, overrun, key_code, intr);
    end
    keys = '0;
    ack_pulse();
    frames(2);
  endtask

  task automatic test_priority_reset();
    int n0;
    keys = '0; keys[K1] = 1'b1; keys[K9] = 1'b1;
    exp_q.push_back(4'd1);
    frames(2);
    tests++;
    if (key_code !== 4'd1) begin
      fails++;
      $display("FAIL priority code=%0d expected 1", key_code);
    end
    keys = '0;
    ack_pulse();
    frames(2);
    keys[K7] = 1'b1;
    frames(1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (col !== 4'b0001 || key_code !== 4'd0 || key_valid !== 1'b0 || intr !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset col=%b code=%0d v=%b i=%b o=%b expected 0001/0/0/0/0",
               col, key_code, key_valid, intr, overrun);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = intr_cnt;
    frames(1);
    tests++;
    if (intr_cnt - n0 !== 0 || key_valid !== 1'b0) begin
      fails++;
      $display("FAIL early_after_reset intrs=%0d v=%b expected 0/0", intr_cnt - n0, key_valid);
    end
    exp_q.push_back(4'd7);
    frames(1);
    tests++;
    if (intr !== 1'b1 || key_code !== 4'd7 || key_valid !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_press i=%b code=%0d v=%b expected 1/7/1", intr, key_code, key_valid);
    end
    keys = '0;
    ack_pulse();
    frames(2);
  endtask

  initial begin
    test_reset();
    test_press_ack();
    test_bounce();
    test_hold_release();
    test_overrun();
    test_priority_reset();
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL missing_reports pending=%0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
